// File: rtl/deskew_matrix_if.sv
// Stream interface for deskew_matrix: skewed input beats in, a whole SIZE x SIZE
// matrix out. The err signal is present only when DESKEW_PAD_CHECK_EN is defined.
interface deskew_matrix_if #(
  parameter int WIDTH = 4,
  parameter int SIZE  = 3
);
  logic                                  in_valid;
  logic [SIZE*WIDTH-1:0]                 in_data;
  logic                                  in_ready;
  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]  Mout;
  logic                                  out_valid;
  logic                                  out_ready;
`ifdef DESKEW_PAD_CHECK_EN
  logic                                  err;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, Mout, out_valid, err);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, Mout, out_valid, err);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, Mout, out_valid);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, Mout, out_valid);
`endif
endinterface

// File: rtl/deskew_matrix.sv
// deskew_matrix: reassembles a SIZE x SIZE matrix from 2*SIZE-1 diagonally skewed
// beats (beat k, lane j carries M[k-j][j]). Each lane owns one matrix column.
// A single output register plus one pending frame in the capture array give
// back-to-back throughput with a simple ready/valid stall.
// Optional feature: define DESKEW_PAD_CHECK_EN to get a sticky err output that
// flags nonzero padding lanes.

// One column of the capture array; lane LANE takes row (cnt - LANE) when in range.
module deskew_lane #(
  parameter int WIDTH = 4,
  parameter int SIZE  = 3,
  parameter int LANE  = 0,
  parameter int CW    = 3
) (
  input  logic                         clock,
  input  logic                         nreset,
  input  logic                         clear,
  input  logic                         acc,
  input  logic [CW-1:0]                cnt,
  input  logic [WIDTH-1:0]             din,
`ifdef DESKEW_PAD_CHECK_EN
  output logic                         pad,
`endif
  output logic [SIZE-1:0][WIDTH-1:0]   col_nxt
);
  logic [SIZE-1:0][WIDTH-1:0] col;

  // Column as it will look after this edge, including the current beat.
  always_comb begin
    col_nxt = col;
    for (int r = 0; r < SIZE; r++)
      if (acc && int'(cnt) == LANE + r) col_nxt[r] = din;
  end

`ifdef DESKEW_PAD_CHECK_EN
  // A lane outside its diagonal window must carry zero.
  always_comb begin
    pad = acc && !((int'(cnt) >= LANE) && (int'(cnt) < LANE + SIZE)) && (din != '0);
  end
`endif

  // Capture storage; clear throws away a partial frame.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)    col <= '0;
    else if (clear) col <= '0;
    else            col <= col_nxt;
  end
endmodule

module deskew_matrix #(
  parameter int WIDTH = 4,
  parameter int SIZE  = 3
) (
  input  logic            clock,
  input  logic            nreset,
  input  logic            clear,
  deskew_matrix_if.slave  bus
);
  localparam int BEATS = 2*SIZE - 1;
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic [0:0]                           state;
  logic [CW-1:0]                        cnt;
  logic                                 acc, last, load, xfer, out_valid;
  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] col_nxt;  // [lane][row]
  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] full;     // [row][col]
  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] mout;
`ifdef DESKEW_PAD_CHECK_EN
  logic [SIZE-1:0]                      pad;
  logic                                 err;
`endif

  assign bus.in_ready  = (state == COLLECT);
  // clear wins over a beat presented on the same edge.
  assign acc  = bus.in_valid && bus.in_ready && !clear;
  assign last = (cnt == LAST);
  // Last beat with a free output register goes straight to Mout.
  assign load = acc && last && (!out_valid || bus.out_ready);
  // A parked frame moves to Mout once the consumer takes the old one.
  assign xfer = !clear && (state == PENDING) && bus.out_ready;

  genvar j, r;
  generate
    for (j = 0; j < SIZE; j++) begin : g_lane
      deskew_lane #(.WIDTH(WIDTH), .SIZE(SIZE), .LANE(j), .CW(CW)) u_lane (
        .clock   (clock),
        .nreset  (nreset),
        .clear   (clear),
        .acc     (acc),
        .cnt     (cnt),
        .din     (bus.in_data[j*WIDTH +: WIDTH]),
`ifdef DESKEW_PAD_CHECK_EN
        .pad     (pad[j]),
`endif
        .col_nxt (col_nxt[j])
      );
      for (r = 0; r < SIZE; r++) begin : g_row
        assign full[r][j] = col_nxt[j][r];
      end
    end
  endgenerate

  // Beat index within the frame; idle cycles hold it.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)    cnt <= '0;
    else if (clear) cnt <= '0;
    else if (acc)   cnt <= last ? '0 : cnt + 1'b1;
  end

  // COLLECT accepts beats; PENDING parks a finished frame behind a busy Mout.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)                    state <= COLLECT;
    else if (clear)                 state <= COLLECT;
    else if (acc && last && !load)  state <= PENDING;
    else if (xfer)                  state <= COLLECT;
  end

  // Output register: held while stalled, replaced on load/xfer, dropped on take.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      mout      <= '0;
      out_valid <= 1'b0;
    end else if (load || xfer) begin
      mout      <= full;
      out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.Mout      = mout;
  assign bus.out_valid = out_valid;

`ifdef DESKEW_PAD_CHECK_EN
  // Sticky padding error, cleared only by reset or clear.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)    err <= 1'b0;
    else if (clear) err <= 1'b0;
    else if (|pad)  err <= 1'b1;
  end
  assign bus.err = err;
`endif
endmodule

// File: tb/tb_deskew_matrix.sv
// Scoreboard bench for deskew_matrix (WIDTH=4, SIZE=3). Stimulus builds skewed
// beats from random matrices; completed frames push the expected matrix, and an
// independent monitor compares on every output handshake.
module tb_deskew_matrix;
  localparam int W = 4;
  localparam int S = 3;
  localparam int NB = 2*S - 1;
`ifdef DESKEW_PAD_CHECK_EN
  localparam bit PADR = 1'b0;
`else
  localparam bit PADR = 1'b1;
`endif

  typedef int mat_t [S][S];

  logic clock = 1'b0;
  logic nreset = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  deskew_matrix_if #(.WIDTH(W), .SIZE(S)) bus();
  deskew_matrix #(.WIDTH(W), .SIZE(S)) dut (
    .clock  (clock),
    .nreset (nreset),
    .clear  (clear),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [S*S*W-1:0] expq[$];
  bit rnd_mode = 1'b0;
  bit rnd_rdy  = 1'b0;
  bit fix_rdy  = 1'b1;
  assign bus.out_ready = rnd_mode ? rnd_rdy : fix_rdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [S*S*W-1:0] pack(input mat_t m);
    logic [S*S*W-1:0] p = '0;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++)
        p[(r*S+c)*W +: W] = W'(m[r][c]);
    return p;
  endfunction

  // Beat k, lane j carries M[k-j][j]; everything else is padding.
  function automatic logic [S*W-1:0] beat_of(input mat_t m, input int k, input bit rpad);
    logic [S*W-1:0] b = '0;
    for (int j = 0; j < S; j++) begin
      if (k - j >= 0 && k - j < S) b[j*W +: W] = W'(m[k-j][j]);
      else                         b[j*W +: W] = rpad ? W'($urandom_range(0, 15)) : '0;
    end
    return b;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++)
        m[r][c] = int'($urandom_range(0, 15));
    return m;
  endfunction

  // Presents one beat and returns #1 after the edge that accepts it.
  task automatic send_beat(input logic [S*W-1:0] d);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        @(posedge clock);
        #1;
        ok = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_data  = (S*W)'($urandom);
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL beat_timeout: in_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send_frame(input mat_t m, input int nbeats, input int maxgap, input bit rpad);
    for (int k = 0; k < nbeats; k++) begin
      idle($urandom_range(0, maxgap));
      send_beat(beat_of(m, k, rpad));
    end
    if (nbeats == NB) expq.push_back(pack(m));
  endtask

  // Random consumer back-pressure.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      rnd_rdy = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compare on handshake, check stability while stalled.
  initial begin
    logic [S*S*W-1:0] hm, e;
    bit hv;
    hv = 1'b0;
    hm = '0;
    forever begin
      @(negedge clock);
      if (!nreset) hv = 1'b0;
      else begin
        if (hv) begin
          check("hold_valid", 64'(bus.out_valid), 64'd1);
          check("hold_mout", 64'(bus.Mout), 64'(hm));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_out: out_valid=1 Mout=%h, required no output", bus.Mout);
          end else begin
            e = expq.pop_front();
            check("mout", 64'(bus.Mout), 64'(e));
          end
        end
        hv = bus.out_valid && !bus.out_ready;
        hm = bus.Mout;
      end
    end
  end

  initial begin
    logic [S*W-1:0] lit [NB];
    mat_t m0, m1, m2, ma, mb, mc, md, mp;
    logic [S*S*W-1:0] lastm;

    lit[0] = 12'h001; lit[1] = 12'h027; lit[2] = 12'h368; lit[3] = 12'h590; lit[4] = 12'h400;
    m0[0][0] = 1; m0[0][1] = 2; m0[0][2] = 3;
    m0[1][0] = 7; m0[1][1] = 6; m0[1][2] = 5;
    m0[2][0] = 8; m0[2][1] = 9; m0[2][2] = 4;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mout", 64'(bus.Mout), 64'd0);
`ifdef DESKEW_PAD_CHECK_EN
    check("rst_err", 64'(bus.err), 64'd0);
`endif
    nreset = 1'b1;
    idle(1);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Reference vector, no gaps, out_ready high.
    for (int k = 0; k < NB - 1; k++) send_beat(lit[k]);
    check("ref_no_early_valid", 64'(bus.out_valid), 64'd0);
    expq.push_back(pack(m0));
    send_beat(lit[NB-1]);
    check("ref_valid_latency", 64'(bus.out_valid), 64'd1);
    check("ref_mout", 64'(bus.Mout), 64'(pack(m0)));
    idle(2);

    // Same vector with idle gaps.
    for (int k = 0; k < NB; k++) begin
      idle(1 + $urandom_range(0, 2));
      if (k == NB - 1) begin
        check("gap_no_early_valid", 64'(bus.out_valid), 64'd0);
        expq.push_back(pack(m0));
      end
      send_beat(lit[k]);
    end
    idle(2);

    // Two frames against a stalled consumer.
    fix_rdy = 1'b0;
    m1 = rand_mat();
    m2 = rand_mat();
    send_frame(m1, NB, 0, PADR);
    send_frame(m2, NB, 0, PADR);
    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    check("stall_mout_first", 64'(bus.Mout), 64'(pack(m1)));
    idle(3);
    check("stall_still_first", 64'(bus.Mout), 64'(pack(m1)));
    fix_rdy = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("stall_second_out", 64'(bus.Mout), 64'(pack(m2)));
    check("stall_in_ready_back", 64'(bus.in_ready), 64'd1);
    idle(3);

    // Reset in the middle of a frame.
    ma = rand_mat();
    send_frame(ma, 3, 0, PADR);
    #2 nreset = 1'b0;
    #3;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_mout", 64'(bus.Mout), 64'd0);
    @(posedge clock);
    #1 nreset = 1'b1;
    mb = rand_mat();
    send_frame(mb, NB, 1, PADR);
    idle(3);

    // clear arriving with beat 3.
    lastm = pack(mb);
    mc = rand_mat();
    send_frame(mc, 3, 0, PADR);
    clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = beat_of(mc, 3, PADR);
    @(posedge clock);
    #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check("clear_mout_kept", 64'(bus.Mout), 64'(lastm));
    check("clear_no_valid", 64'(bus.out_valid), 64'd0);
    md = rand_mat();
    send_frame(md, NB, 1, PADR);
    idle(3);

    // Nonzero padding in beat 0.
    mp = rand_mat();
    mp[0][0] = 1;
    send_beat(12'h101);
`ifdef DESKEW_PAD_CHECK_EN
    check("pad_err_set", 64'(bus.err), 64'd1);
`endif
    for (int k = 1; k < NB; k++) begin
      if (k == NB - 1) expq.push_back(pack(mp));
      send_beat(beat_of(mp, k, 1'b0));
    end
    idle(2);
`ifdef DESKEW_PAD_CHECK_EN
    check("pad_err_sticky", 64'(bus.err), 64'd1);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    check("pad_err_cleared", 64'(bus.err), 64'd0);
`endif

    // Random frames, gaps and back-pressure.
    rnd_mode = 1'b1;
    for (int f = 0; f < 25; f++) send_frame(rand_mat(), NB, 2, PADR);
    rnd_mode = 1'b0;
    fix_rdy  = 1'b1;
    for (int i = 0; i < 100 && expq.size() > 0; i++) idle(1);
    check("drain_empty", 64'(expq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/deskew_matrix.md
DESKEW_MATRIX -- requirements
Module: deskew_matrix

Interface
REQ-001 Parameter WIDTH, default 4, element width in bits.
REQ-002 Parameter SIZE, default 3, matrix dimension (SIZE x SIZE), SIZE >= 2.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 nreset  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous abort of partially collected frame.
REQ-006 in_valid  input  1  beat present on in_data.
REQ-007 in_data  input  SIZE*WIDTH  skewed beat; lane j = bits [j*WIDTH +: WIDTH].
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 Mout  output  [WIDTH-1:0] array [SIZE-1:0][SIZE-1:0]  reassembled matrix, Mout[r][c].
REQ-010 out_valid  output  1  Mout holds a complete matrix.
REQ-011 out_ready  input  1  consumer takes Mout.
REQ-012 err  output  1  sticky padding error; port exists only with DESKEW_PAD_CHECK_EN.

Function
REQ-013 Beat accepted when in_valid && in_ready; a frame is exactly 2*SIZE-1 accepted beats, beat index k = 0..2*SIZE-2.
REQ-014 Beat k, lane j: if 0 <= k-j < SIZE, element M[k-j][j]; otherwise padding, ignored for data.
REQ-015 Beat counter: 0 to 2*SIZE-2, increments per accepted beat, wraps to 0 after last beat; idle cycles (in_valid low) do not advance it.
REQ-016 Capture array written lane-wise per REQ-014 on each accepted beat; never drives Mout directly.
REQ-017 States: COLLECT (counter counting, in_ready=1), PENDING (full frame captured, output register busy, in_ready=0).
REQ-018 On accepting last beat with output register free (out_valid=0 or out_ready=1 same cycle): Mout loaded with full frame (capture plus last-beat lanes) at that edge; out_valid=1 from next cycle; stay COLLECT, counter 0.
REQ-019 On accepting last beat with output register busy: enter PENDING; transfer to Mout and return to COLLECT on the edge where out_ready=1.
REQ-020 Mout and out_valid stable while out_valid && !out_ready; out_valid clears on out_ready unless a new transfer occurs same edge (then stays 1, new data).
REQ-021 Back-to-back frames without idle beats sustain one matrix per 2*SIZE-1 cycles when out_ready held high.
REQ-022 clear: counter to 0, PENDING to COLLECT, capture discarded; Mout/out_valid untouched; clear wins over a simultaneous beat (beat dropped).

Reset
REQ-023 nreset low: counter=0, state COLLECT, out_valid=0, Mout all zero, capture zero, err=0; in_ready=1 after release.
REQ-024 Reset mid-frame discards partial frame; first beat after release is beat 0.

Configuration
REQ-025 Macro DESKEW_PAD_CHECK_EN defined: err port present; err sets on any accepted beat with nonzero padding lane, holds until nreset or clear.
REQ-026 Macro undefined: no err port, no check logic; padding lanes ignored silently.

Verification (WIDTH=4, SIZE=3, M = rows 123/765/894)
REQ-027 Beats 0x001,0x027,0x368,0x590,0x400, out_ready=1 -> out_valid one cycle after last beat, Mout = 1,2,3 / 7,6,5 / 8,9,4.
REQ-028 Same frame with in_valid gaps between beats -> identical Mout; out_valid only after 5th accepted beat.
REQ-029 out_ready=0, two frames back-to-back -> in_ready drops after second frame's last beat; first matrix held stable; raise out_ready -> second matrix appears next cycle, in_ready=1.
REQ-030 nreset pulsed after beat 2, then full frame -> Mout equals new frame only; no spurious out_valid.
REQ-031 clear with beat 3, then full frame -> correct matrix from new frame; prior Mout unchanged until then.
REQ-032 With DESKEW_PAD_CHECK_EN, beat 0 = 0x101 -> err=1 from next cycle, stays 1 until clear; without macro, same stimulus -> Mout[0][0]=1, no error port.
